alu_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares one `alu_seq` instance among NUM_REQ requesters. It accepts one operation at a time over per-requester valid/ready handshakes and drives the ALU's operands and opcode. It returns the registered ALU result on a single response channel, tagged with the requester ID. The block sits between the team's client blocks and the single shared ALU, which it instantiates internally.

---
 rtl/alu_arbiter.sv | 207 ++++++++++++++++++++
 tb/tb_alu_arbiter.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// Round-robin arbiter/sequencer sharing one registered ALU (alu_seq) among NUM_REQ requesters.
// Optional macro ALU_ARB_DIV0_CHECK_EN: divide-by-zero bypass with resp_err reporting.

package mm;
  typedef enum logic [1:0] {
    ADD  = 2'd0,
    SUB  = 2'd1,
    MULT = 2'd2,
    DIV  = 2'd3
  } opcode_e;
endpackage

module alu_seq (
  input  logic              clk,
  input  logic              rst,
  input  logic signed [7:0] i_op1,
  input  logic signed [7:0] i_op2,
  input  mm::opcode_e       i_opcode,
  output logic signed [7:0] o_result
);
  logic signed [15:0] w_prod;
  logic signed [8:0]  w_a9;
  logic signed [8:0]  w_b9;
  logic signed [8:0]  w_quot;
  logic signed [7:0]  w_res;
  logic signed [7:0]  r_result;

  // Combinational arithmetic; division is done at 9 bits so -128/-1 wraps cleanly.
  always_comb begin
    w_prod = i_op1 * i_op2;
    w_a9   = {i_op1[7], i_op1};
    w_b9   = {i_op2[7], i_op2};
    if (i_op2 == 8'sd0) begin
      w_quot = 9'sd0;
    end else begin
      w_quot = w_a9 / w_b9;
    end
    case (i_opcode)
      mm::ADD:  w_res = i_op1 + i_op2;
      mm::SUB:  w_res = i_op1 - i_op2;
      mm::MULT: w_res = w_prod[7:0];
      mm::DIV:  w_res = w_quot[7:0];
      default:  w_res = 8'sd0;
    endcase
  end

  // Result register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_result <= 8'sd0;
    end else begin
      r_result <= w_res;
    end
  end

  assign o_result = r_result;
endmodule

module alu_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_REQ-1:0]     req_valid,
  output logic [NUM_REQ-1:0]     req_ready,
  input  logic [8*NUM_REQ-1:0]   req_op1,
  input  logic [8*NUM_REQ-1:0]   req_op2,
  input  logic [2*NUM_REQ-1:0]   req_opcode,
  output logic                   resp_valid,
  input  logic                   resp_ready,
  output logic signed [7:0]      resp_data,
  output logic [ID_W-1:0]        resp_id,
  output logic                   resp_err
);
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_e;

  state_e              r_state;
  state_e              w_next;
  logic [ID_W-1:0]     r_rr_ptr;
  logic [ID_W-1:0]     r_id;
  logic signed [7:0]   r_op1;
  logic signed [7:0]   r_op2;
  mm::opcode_e         r_opcode;

  logic                w_any;
  int                  w_idx;
  logic [ID_W-1:0]     w_grant;
  logic signed [7:0]   w_sel_op1;
  logic signed [7:0]   w_sel_op2;
  mm::opcode_e         w_sel_opcode;
  logic                w_accept;
  logic                w_resp_hs;
  logic signed [7:0]   w_alu_out;

  // Round-robin search: first valid requester at or after r_rr_ptr, wrapping.
  always_comb begin
    w_any        = 1'b0;
    w_idx        = 0;
    w_grant      = '0;
    w_sel_op1    = 8'sd0;
    w_sel_op2    = 8'sd0;
    w_sel_opcode = mm::ADD;
    for (int i = 0; i < NUM_REQ; i++) begin
      w_idx = int'(r_rr_ptr) + i;
      w_idx = (w_idx >= NUM_REQ) ? (w_idx - NUM_REQ) : w_idx;
      if (!w_any && req_valid[w_idx]) begin
        w_any        = 1'b1;
        w_grant      = w_idx[ID_W-1:0];
        w_sel_op1    = req_op1[8*w_idx +: 8];
        w_sel_op2    = req_op2[8*w_idx +: 8];
        w_sel_opcode = mm::opcode_e'(req_opcode[2*w_idx +: 2]);
      end else begin
        w_any = w_any;
      end
    end
  end

  // Next-state and handshake decode.
  always_comb begin
    w_next    = r_state;
    req_ready = '0;
    w_accept  = 1'b0;
    w_resp_hs = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_any) begin
          req_ready[w_grant] = 1'b1;
          w_accept           = 1'b1;
          w_next             = EXEC;
        end else begin
          w_next = IDLE;
        end
      end
      EXEC: w_next = RESP;
      RESP: begin
        if (resp_ready) begin
          w_resp_hs = 1'b1;
          w_next    = IDLE;
        end else begin
          w_next = RESP;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  // State, pointer and operand latches.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= IDLE;
      r_rr_ptr <= '0;
      r_id     <= '0;
      r_op1    <= 8'sd0;
      r_op2    <= 8'sd0;
      r_opcode <= mm::ADD;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_id     <= w_grant;
        r_op1    <= w_sel_op1;
        r_op2    <= w_sel_op2;
        r_opcode <= w_sel_opcode;
      end
      if (w_resp_hs) begin
        r_rr_ptr <= (r_id == ID_W'(NUM_REQ - 1)) ? '0 : (r_id + ID_W'(1));
      end
    end
  end

  alu_seq u_alu (
    .clk      (clk),
    .rst      (rst),
    .i_op1    (r_op1),
    .i_op2    (r_op2),
    .i_opcode (r_opcode),
    .o_result (w_alu_out)
  );

  assign resp_valid = (r_state == RESP);
  assign resp_id    = r_id;

`ifdef ALU_ARB_DIV0_CHECK_EN
  logic r_div0;

  // Divide-by-zero is flagged at accept and masks the ALU result.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_div0 <= 1'b0;
    end else if (w_accept) begin
      r_div0 <= (w_sel_opcode == mm::DIV) && (w_sel_op2 == 8'sd0);
    end else begin
      r_div0 <= r_div0;
    end
  end

  assign resp_data = r_div0 ? 8'sd0 : w_alu_out;
  assign resp_err  = r_div0;
`else
  assign resp_data = w_alu_out;
  assign resp_err  = 1'b0;
`endif
endmodule

// File: tb/tb_alu_arbiter.sv
// Directed self-checking bench for alu_arbiter (NUM_REQ=4).
module tb_alu_arbiter;
  logic        clk;
  logic        rst;
  logic [3:0]  req_valid;
  logic [3:0]  req_ready;
  logic [31:0] req_op1;
  logic [31:0] req_op2;
  logic [7:0]  req_opcode;
  logic        resp_valid;
  logic        resp_ready;
  logic [7:0]  resp_data;
  logic [1:0]  resp_id;
  logic        resp_err;

  int total = 0;
  int bad   = 0;

  alu_arbiter dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_op1    (req_op1),
    .req_op2    (req_op2),
    .req_opcode (req_opcode),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_data  (resp_data),
    .resp_id    (resp_id),
    .resp_err   (resp_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int id, input logic [1:0] op, input logic [7:0] a, input logic [7:0] b);
    req_op1[8*id +: 8]    = a;
    req_op2[8*id +: 8]    = b;
    req_opcode[2*id +: 2] = op;
    req_valid[id]         = 1'b1;
  endtask

  task automatic tick;
    @(posedge clk);
    #2;
  endtask

  // Single requester, resp_ready=1: ready now, EXEC next, response two edges after accept.
  task automatic run_one(input string tag, input int id, input logic [1:0] op,
                         input logic [7:0] a, input logic [7:0] b,
                         input logic [7:0] exp_data, input logic exp_err);
    set_req(id, op, a, b);
    #1;
    check({tag, "_ready"}, {28'd0, req_ready}, 32'd1 << id);
    tick();
    req_valid[id] = 1'b0;
    check({tag, "_exec_valid"}, {31'd0, resp_valid}, 32'd0);
    tick();
    check({tag, "_valid"}, {31'd0, resp_valid}, 32'd1);
    check({tag, "_data"}, {24'd0, resp_data}, {24'd0, exp_data});
    check({tag, "_id"}, {30'd0, resp_id}, id);
    check({tag, "_err"}, {31'd0, resp_err}, {31'd0, exp_err});
    tick();
  endtask

  int          exp_ids  [5] = '{0, 1, 2, 3, 1};
  logic [7:0]  exp_datas[5] = '{8'd0, 8'd2, 8'd4, 8'd6, 8'd15};

  initial begin
    rst        = 1'b1;
    req_valid  = 4'd0;
    req_op1    = 32'd0;
    req_op2    = 32'd0;
    req_opcode = 8'd0;
    resp_ready = 1'b1;
    tick();
    tick();
    check("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    check("rst_req_ready", {28'd0, req_ready}, 32'd0);
    check("rst_resp_data", {24'd0, resp_data}, 32'd0);
    check("rst_resp_id", {30'd0, resp_id}, 32'd0);
    check("rst_resp_err", {31'd0, resp_err}, 32'd0);
    rst = 1'b0;

    run_one("add_100_27", 2, 2'd0, 8'd100, 8'd27, 8'd127, 1'b0);
    run_one("sub_m128_1", 0, 2'd1, 8'h80, 8'd1, 8'h7f, 1'b0);
    run_one("mult_16_16", 0, 2'd2, 8'd16, 8'd16, 8'h00, 1'b0);
    run_one("div_m7_2", 1, 2'd3, 8'hf9, 8'd2, 8'hfd, 1'b0);
    run_one("mult_m3_5", 3, 2'd2, 8'hfd, 8'd5, 8'hf1, 1'b0);

    // Contention from reset: order 0,1,2,3 then requester 1 again (3 beat it at ptr=3).
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) set_req(i, 2'd0, 8'(i), 8'(i));
    for (int k = 0; k < 5; k++) begin
      #1;
      check("cont_ready", {28'd0, req_ready}, 32'd1 << exp_ids[k]);
      tick();
      if (k == 1) set_req(1, 2'd0, 8'd10, 8'd5);
      else req_valid[exp_ids[k]] = 1'b0;
      tick();
      check("cont_valid", {31'd0, resp_valid}, 32'd1);
      check("cont_data", {24'd0, resp_data}, {24'd0, exp_datas[k]});
      check("cont_id", {30'd0, resp_id}, exp_ids[k]);
      tick();
    end
    check("cont_drained", {28'd0, req_valid}, 32'd0);

    // Backpressure: ptr=2, requesters 0 and 3 pending -> 3 first, held 5 cycles.
    resp_ready = 1'b0;
    set_req(3, 2'd1, 8'd10, 8'd3);
    set_req(0, 2'd2, 8'hfd, 8'd5);
    #1;
    check("bp_ready_first", {28'd0, req_ready}, 32'd8);
    tick();
    req_valid[3] = 1'b0;
    tick();
    for (int c = 0; c < 5; c++) begin
      check("bp_hold_valid", {31'd0, resp_valid}, 32'd1);
      check("bp_hold_data", {24'd0, resp_data}, 32'd7);
      check("bp_hold_id", {30'd0, resp_id}, 32'd3);
      check("bp_hold_noready", {28'd0, req_ready}, 32'd0);
      if (c == 4) resp_ready = 1'b1;
      tick();
    end
    check("bp_next_ready", {28'd0, req_ready}, 32'd1);
    tick();
    req_valid[0] = 1'b0;
    tick();
    check("bp_second_data", {24'd0, resp_data}, 32'hf1);
    check("bp_second_id", {30'd0, resp_id}, 32'd0);
    tick();

    // Reset during EXEC drops the operation and rewinds rr_ptr (currently 1) to 0.
    set_req(2, 2'd0, 8'd1, 8'd1);
    tick();
    req_valid[2] = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rstmid_valid", {31'd0, resp_valid}, 32'd0);
    tick();
    check("rstmid_no_resp", {31'd0, resp_valid}, 32'd0);
    set_req(3, 2'd0, 8'd7, 8'd7);
    set_req(0, 2'd0, 8'd5, 8'd6);
    #1;
    check("rstmid_ptr0", {28'd0, req_ready}, 32'd1);
    tick();
    req_valid[0] = 1'b0;
    tick();
    check("rstmid_data", {24'd0, resp_data}, 32'd11);
    tick();
    check("rstmid_next_ready", {28'd0, req_ready}, 32'd8);
    tick();
    req_valid[3] = 1'b0;
    tick();
    check("rstmid_data3", {24'd0, resp_data}, 32'd14);
    tick();

`ifdef ALU_ARB_DIV0_CHECK_EN
    run_one("div0", 1, 2'd3, 8'd50, 8'd0, 8'd0, 1'b1);
    run_one("div_after_div0", 1, 2'd3, 8'd50, 8'd5, 8'd10, 1'b0);
`else
    set_req(1, 2'd3, 8'd50, 8'd0);
    tick();
    req_valid[1] = 1'b0;
    tick();
    check("div0_valid", {31'd0, resp_valid}, 32'd1);
    check("div0_err_off", {31'd0, resp_err}, 32'd0);
    tick();
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
